// File: rtl/wt_fetch1.sv
// wt_fetch1: layer-1 weight fetch sequencer for the dual-port 144-bit weight ROM.
// Walks a contiguous word range (wrapping at DEPTH) two words per cycle, absorbs
// the 1-cycle ROM latency and streams kernel pairs out through a small FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, num_words request pulse, first word, word count (sampled in IDLE)
//   busy, done                 request active, one-cycle completion pulse
//   addr_a, addr_b             registered ROM port addresses (even / odd word)
//   q_a, q_b                   ROM read data, valid one cycle after the address edge
//   out_valid, out_ready       output handshake
//   out_kernel_a, out_kernel_b head beat kernels (word n, word n+1)
//   out_lane_b                 out_kernel_b meaningful (0 only on last beat of an odd count)
module wt_fetch1 #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 144,
    parameter int DEPTH      = 76,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_kernel_a,
    output logic [DATA_WIDTH-1:0] out_kernel_b,
    output logic                  out_lane_b
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur, pairs_left;
    logic                  odd;
    logic [1:0]            tag_v, tag_lane;
    logic [1:0]            inflight;
    logic [CW:0]           used;
    logic                  issue, last, last_odd, push, pop;
    logic [DATA_WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic                  mem_l [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         fifo_count;

    // Addresses are summed one bit wider so the wrap compare sees the carry.
    function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [ADDR_WIDTH:0] v);
        return (v >= DEPTH_W) ? ADDR_WIDTH'(v - DEPTH_W) : v[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inflight = 2'(tag_v[0]) + 2'(tag_v[1]);
    assign used     = {1'b0, fifo_count} + (CW+1)'(inflight);
    // Counting in-flight reads against the FIFO budget guarantees every capture has a free slot.
    assign issue    = (state == S_FETCH) && (pairs_left != '0) && (used < (CW+1)'(FIFO_DEPTH));
    assign last     = pairs_left == ADDR_WIDTH'(1);
    assign last_odd = last && odd;
    assign push     = tag_v[1];
    assign out_valid = fifo_count != '0;
    assign pop      = out_valid && out_ready;
    assign busy     = (state == S_FETCH) || (state == S_DRAIN);
    assign done     = state == S_DONE;
    assign out_kernel_a = mem_a[rd_ptr];
    assign out_kernel_b = mem_b[rd_ptr];
    assign out_lane_b   = mem_l[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // DRAIN leaves on the cycle of the final pop so done lands right after the last beat.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = !start ? S_IDLE : (num_words == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nx = (issue && last) ? S_DRAIN : S_FETCH;
            S_DRAIN: state_nx = (inflight == 2'd0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) ? S_DONE : S_DRAIN;
            S_DONE:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            pairs_left <= '0;
            odd        <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            tag_v      <= '0;
            tag_lane   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cur        <= base_addr;
                pairs_left <= ADDR_WIDTH'(({1'b0, num_words} + 1'b1) >> 1);
                odd        <= num_words[0];
            end
            tag_v    <= {tag_v[0], issue};
            tag_lane <= {tag_lane[0], !last_odd};
            if (issue) begin
                addr_a     <= cur;
                addr_b     <= last_odd ? cur : wrap({1'b0, cur} + 1'b1);
                cur        <= wrap({1'b0, cur} + 2'd2);
                pairs_left <= pairs_left - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_l[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= q_a;
                mem_b[wr_ptr] <= q_b;
                mem_l[wr_ptr] <= tag_lane[1];
                wr_ptr        <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_wt_fetch1.sv
// tb_wt_fetch1: self-checking bench for wt_fetch1 with a random-content ROM model.
// Expected beats are derived from (base, count) with modular arithmetic and kept in queues.
module tb_wt_fetch1;
    logic         clk = 1'b0;
    logic         rst_n, start, out_ready;
    logic [6:0]   base_addr, num_words, addr_a, addr_b;
    logic [143:0] q_a, q_b, out_kernel_a, out_kernel_b;
    logic         busy, done, out_valid, out_lane_b;
    logic [143:0] rom [128];
    int           errors = 0;
    int           checks = 0;

    wt_fetch1 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_kernel_a(out_kernel_a),
        .out_kernel_b(out_kernel_b), .out_lane_b(out_lane_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q_a <= rom[addr_a];
        q_b <= rom[addr_b];
    end

    always @(posedge clk)
        if (rst_n && dut.push)
            assert (dut.fifo_count < 3'd4) else $error("FAIL fifo_overflow: count=%0d limit=3", dut.fifo_count);

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; num_words = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if ({addr_a, addr_b} !== 14'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", addr_a, addr_b); end
        checks++; if ({out_kernel_a, out_kernel_b, out_lane_b} !== '0) begin errors++; $display("FAIL reset_head: got %h/%h/%b want 0", out_kernel_a, out_kernel_b, out_lane_b); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, out_valid} !== 3'b000) begin errors++; $display("FAIL reset_release: got %b want 000", {busy, done, out_valid}); end
    endtask

    // mode 0: out_ready held high; mode 1: random ready with a 10-cycle low window.
    task automatic run_req(input int base, input int n, input int mode, input bit dbl);
        int qa[$]; int qb[$]; bit ql[$];
        int np, cyc, beat, done_cnt, done_cyc, last_acc;
        bit rdy, stall;
        logic [143:0] ha, hb;
        logic hl;
        np = (n + 1) / 2;
        for (int i = 0; i < np; i++) begin
            qa.push_back((base + 2 * i) % 76);
            qb.push_back((base + 2 * i + 1) % 76);
            ql.push_back(!(n % 2 == 1 && i == np - 1));
        end
        beat = 0; done_cnt = 0; done_cyc = 0; last_acc = -1; stall = 0; ha = '0; hb = '0; hl = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 7'(base); num_words = 7'(n); out_ready = 1'b0;
        @(negedge clk);
        for (cyc = 0; cyc < 600; cyc++) begin
            start = dbl && cyc == 1;
            if (dbl && cyc == 1) begin base_addr = 7'((base + 5) % 76); num_words = 7'd9; end
            if (cyc == 0) begin
                checks++; if (busy !== (n != 0)) begin errors++; $display("FAIL busy_rise: got %b want %b", busy, n != 0); end
            end
            if (cyc == 1 && n != 0) begin
                checks++; if (addr_a !== 7'(base) || addr_b !== 7'(n == 1 ? base : (base + 1) % 76)) begin
                    errors++; $display("FAIL first_addr: got %0d/%0d want %0d/%0d", addr_a, addr_b, base, n == 1 ? base : (base + 1) % 76);
                end
            end
            if (stall) begin
                checks++; if (out_valid !== 1'b1 || {out_kernel_a, out_kernel_b, out_lane_b} !== {ha, hb, hl}) begin
                    errors++; $display("FAIL head_stable: got v=%b %h want v=1 %h", out_valid, out_kernel_a, ha);
                end
            end
            rdy = mode == 0 || (!(cyc >= 12 && cyc < 22) && $urandom_range(0, 1) == 1);
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL extra_beat: got beat %0d want none (base %0d n %0d)", beat, base, n);
                end else begin
                    if (out_kernel_a !== rom[qa[0]]) begin errors++; $display("FAIL kernel_a beat %0d: got %h want %h", beat, out_kernel_a, rom[qa[0]]); end
                    checks++; if (out_lane_b !== ql[0]) begin errors++; $display("FAIL lane_b beat %0d: got %b want %b", beat, out_lane_b, ql[0]); end
                    if (ql[0]) begin
                        checks++; if (out_kernel_b !== rom[qb[0]]) begin errors++; $display("FAIL kernel_b beat %0d: got %h want %h", beat, out_kernel_b, rom[qb[0]]); end
                    end
                    if (mode == 0) begin
                        checks++; if (cyc != 3 + beat) begin errors++; $display("FAIL beat_timing beat %0d: got cycle %0d want %0d", beat, cyc, 3 + beat); end
                    end
                    void'(qa.pop_front()); void'(qb.pop_front()); void'(ql.pop_front());
                end
                beat++; last_acc = cyc;
            end
            stall = out_valid === 1'b1 && !rdy;
            ha = out_kernel_a; hb = out_kernel_b; hl = out_lane_b;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    checks++; if (cyc != (n == 0 ? 0 : last_acc + 1)) begin errors++; $display("FAIL done_timing: got cycle %0d want %0d", cyc, n == 0 ? 0 : last_acc + 1); end
                    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count (base %0d n %0d): got %0d want 1", base, n, done_cnt); end
        checks++; if (beat != np) begin errors++; $display("FAIL beat_count (base %0d n %0d): got %0d want %0d", base, n, beat, np); end
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_full;         run_req(0, 76, 0, 1'b0);  endtask
    task automatic test_odd;          run_req(10, 5, 0, 1'b0);  endtask
    task automatic test_wrap;         run_req(75, 3, 0, 1'b0);  endtask
    task automatic test_backpressure; run_req(0, 20, 1, 1'b0);  endtask
    task automatic test_zero;         run_req(33, 0, 0, 1'b0);  endtask
    task automatic test_busy_start;   run_req(30, 8, 0, 1'b1);  endtask

    task automatic test_random;
        repeat (6) run_req($urandom_range(0, 75), $urandom_range(1, 76), $urandom_range(0, 1), 1'b0);
    endtask

    task automatic test_reset_mid;
        int acc;
        acc = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 7'd20; num_words = 7'd40; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30 && acc < 2; c++) begin
            if (out_valid === 1'b1) acc++;
            if (acc < 2) @(negedge clk);
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL midreset_beats: got %0d want 2", acc); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, out_valid, out_lane_b} !== 4'b0) begin errors++; $display("FAIL midreset_ctrl: got %b want 0000", {busy, done, out_valid, out_lane_b}); end
        checks++; if ({addr_a, addr_b} !== 14'd0) begin errors++; $display("FAIL midreset_addr: got %0d/%0d want 0/0", addr_a, addr_b); end
        checks++; if ({out_kernel_a, out_kernel_b} !== '0) begin errors++; $display("FAIL midreset_head: got %h/%h want 0", out_kernel_a, out_kernel_b); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if ({busy, done, out_valid} !== 3'b000) begin errors++; $display("FAIL midreset_quiet cycle %0d: got %b want 000", c, {busy, done, out_valid}); end
        end
        out_ready = 1'b0;
        run_req(70, 11, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
        test_reset;
        test_full;
        test_odd;
        test_wrap;
        test_backpressure;
        test_zero;
        test_busy_start;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
